// File: rtl/rotary_bank_pkg.sv
// -----------------------------------------------------------------------------
// rotary_bank_pkg
//
// Purpose : Definitions shared by the rotary_bank top level and its per-channel
//           sub-module. It holds the instruction field positions, the opcode
//           values, the Ready/Error state encoding, the {B,A} quadrature codes
//           that the decoder looks for, and a helper that sizes the
//           channel-select register.
//
// Ports   : none (package).
// -----------------------------------------------------------------------------
package rotary_bank_pkg;

  // Instruction word layout: {opcode[3:0], imm[7:0]}.
  localparam int INST_WIDTH = 12;
  localparam int OP_MSB     = 11;
  localparam int OP_LSB     = 8;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  // Opcodes. The values 0x6..0xF are undefined and send the block to Error.
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_RDLS  = 4'h1;
  localparam logic [3:0] OP_RDRS  = 4'h2;
  localparam logic [3:0] OP_SEL   = 4'h3;
  localparam logic [3:0] OP_RDCNT = 4'h4;
  localparam logic [3:0] OP_CLR   = 4'h5;

  // Top-level FSM encoding. The state can leave Error only through reset.
  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_ERROR = 1'b1;

  // One encoder sample, {B,A}.
  typedef logic [1:0] quad_t;

  localparam quad_t Q_A_ONLY = 2'b01;  // the left event needs this code first
  localparam quad_t Q_B_ONLY = 2'b10;  // the right event needs this code first
  localparam quad_t Q_BOTH   = 2'b11;  // both events complete on this code

  // Width of the channel-select register. It is never narrower than one bit,
  // so a single-channel build still has a legal register.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage : rotary_bank_pkg

// File: rtl/rotary_bank_channel.sv
// -----------------------------------------------------------------------------
// rotary_bank_channel
//
// Purpose : One quadrature encoder channel. The {B,A} pins pass through a
//           two-flop synchroniser and an optional debounce filter, then reach
//           an edge decoder. Decoded events set a sticky left or right flag
//           and move a saturating two's-complement position counter.
//
// Build option : define ROTARY_BANK_DEBOUNCE_EN to include the debounce filter.
//           When the macro is undefined, the synchroniser output feeds the
//           decoder directly and DEBOUNCE_CYCLES is ignored.
//
// Ports   :
//   clk_i        clock; all state changes on the rising edge
//   rst_i        asynchronous, active-high reset
//   rot_i[1:0]   raw {B,A} encoder pins (asynchronous)
//   clr_i        zero the counter and both flags (takes priority over events)
//   rd_left_i    read strobe for the left flag; clears the flag
//   rd_right_i   read strobe for the right flag; clears the flag
//   left_o       left flag OR a left event in this cycle
//   right_o      right flag OR a right event in this cycle
//   count_o      current position counter
// -----------------------------------------------------------------------------
module rotary_bank_channel
  import rotary_bank_pkg::*;
#(
  parameter int CNT_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           rot_i,
  input  logic                 clr_i,
  input  logic                 rd_left_i,
  input  logic                 rd_right_i,
  output logic                 left_o,
  output logic                 right_o,
  output logic [CNT_WIDTH-1:0] count_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser
  // ---------------------------------------------------------------------------
  quad_t sync1_q;
  quad_t sync2_q;

  // NOTE: sequential blocks use non-blocking assignments only, so that every
  // flop samples the values that existed before the clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= rot_i;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce filter (optional)
  // ---------------------------------------------------------------------------
  quad_t deb_val;

`ifdef ROTARY_BANK_DEBOUNCE_EN
  // stable_q holds the accepted value. cand_q holds the value that is
  // currently being timed, and stab_cnt_q counts how many consecutive cycles
  // cand_q has been seen. When the input changes, or returns to stable_q, the
  // count restarts, so a short pulse is discarded.
  quad_t      stable_q, stable_d;
  quad_t      cand_q, cand_d;
  logic [7:0] stab_cnt_q, stab_cnt_d;
  logic [7:0] cnt_next;

  // NOTE: every variable gets a default at the top of the block, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    stable_d   = stable_q;
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    cnt_next   = (sync2_q == cand_q) ? stab_cnt_q + 8'd1 : 8'd1;

    if (sync2_q == stable_q) begin
      cand_d     = stable_q;
      stab_cnt_d = '0;
    end else if (cnt_next >= 8'(DEBOUNCE_CYCLES)) begin
      stable_d   = sync2_q;
      cand_d     = sync2_q;
      stab_cnt_d = '0;
    end else begin
      cand_d     = sync2_q;
      stab_cnt_d = cnt_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q   <= '0;
      cand_q     <= '0;
      stab_cnt_q <= '0;
    end else begin
      stable_q   <= stable_d;
      cand_q     <= cand_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  assign deb_val = stable_q;
`else
  // This build has no filter, so every change after the synchroniser reaches
  // the decoder.
  logic unused_debounce_cycles;
  assign unused_debounce_cycles = DEBOUNCE_CYCLES[0];
  assign deb_val = sync2_q;
`endif

  // ---------------------------------------------------------------------------
  // Edge decoder: compare the filtered value with the one from the previous
  // cycle. The two events need different previous codes, so at most one of
  // them can fire in a cycle.
  // ---------------------------------------------------------------------------
  quad_t prev_q;
  logic  ev_left;
  logic  ev_right;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= '0;
    else       prev_q <= deb_val;
  end

  assign ev_left  = (prev_q == Q_A_ONLY) && (deb_val == Q_BOTH);
  assign ev_right = (prev_q == Q_B_ONLY) && (deb_val == Q_BOTH);

  // ---------------------------------------------------------------------------
  // Sticky flags and saturating counter. Priority from low to high is:
  // event, then read, then clear. A read therefore consumes an event that
  // arrives in the same cycle (the read output already includes it), and a
  // clear discards everything.
  // ---------------------------------------------------------------------------
  logic                 left_q, left_d;
  logic                 right_q, right_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    count_d = count_q;

    if (ev_left) begin
      left_d = 1'b1;
      if (count_q != CNT_MIN) count_d = count_q - CNT_ONE;
    end
    if (ev_right) begin
      right_d = 1'b1;
      if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
    end

    if (rd_left_i)  left_d  = 1'b0;
    if (rd_right_i) right_d = 1'b0;

    if (clr_i) begin
      left_d  = 1'b0;
      right_d = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      count_q <= '0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
      count_q <= count_d;
    end
  end

  assign left_o  = left_q  | ev_left;
  assign right_o = right_q | ev_right;
  assign count_o = count_q;

endmodule : rotary_bank_channel

// File: rtl/rotary_bank.sv
// -----------------------------------------------------------------------------
// rotary_bank
//
// Purpose : Multi-channel rotary encoder peripheral on the 12-bit instruction
//           bus. It holds the Ready/Error FSM, the channel-select register,
//           the instruction decode and the registered read results. Each
//           encoder is tracked by one rotary_bank_channel instance.
//
// Build option : ROTARY_BANK_DEBOUNCE_EN enables the per-channel debounce
//           filter (see rotary_bank_channel).
//
// Ports   :
//   clock                 sole clock, rising edge
//   reset                 asynchronous, active-high; clears all state
//   inst[11:0]            {opcode[3:0], imm[7:0]}
//   inst_en               execute inst on this edge
//   rotary[2*CHANNELS-1:0] {B,A} of channel c on rotary[2c+1:2c]
//   rotary_left_status    result of the last RDLS
//   rotary_right_status   result of the last RDRS
//   rotary_count          result of the last RDCNT
//   rotary_error          high while the block is in Error
// -----------------------------------------------------------------------------
module rotary_bank
  import rotary_bank_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int CNT_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [INST_WIDTH-1:0]   inst,
  input  logic                    inst_en,
  input  logic [2*CHANNELS-1:0]   rotary,
  output logic                    rotary_left_status,
  output logic                    rotary_right_status,
  output logic [CNT_WIDTH-1:0]    rotary_count,
  output logic                    rotary_error
);

  localparam int SEL_W = sel_width(CHANNELS);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [0:0]           state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 left_st_q, left_st_d;
  logic                 right_st_q, right_st_d;
  logic [CNT_WIDTH-1:0] count_st_q, count_st_d;

  // Channel-facing strobes; the generate loop routes them to sel_q only.
  logic do_rdl;
  logic do_rdr;
  logic do_clr;

  logic                 chan_left  [CHANNELS];
  logic                 chan_right [CHANNELS];
  logic [CNT_WIDTH-1:0] chan_count [CHANNELS];

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic [3:0] opcode;
  logic [7:0] imm;
  logic       exec;

  assign opcode = inst[OP_MSB:OP_LSB];
  assign imm    = inst[IMM_MSB:IMM_LSB];
  // In Error, instructions are ignored; the channels keep tracking.
  assign exec   = inst_en && (state_q == ST_READY);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    left_st_d  = left_st_q;
    right_st_d = right_st_q;
    count_st_d = count_st_q;
    do_rdl     = 1'b0;
    do_rdr     = 1'b0;
    do_clr     = 1'b0;

    if (exec) begin
      case (opcode)
        OP_NOP: begin
        end
        OP_RDLS: begin
          left_st_d = chan_left[sel_q];
          do_rdl    = 1'b1;
        end
        OP_RDRS: begin
          right_st_d = chan_right[sel_q];
          do_rdr     = 1'b1;
        end
        OP_SEL: begin
          // The new selection applies from the next instruction onward.
          if (32'(imm) < 32'(CHANNELS)) sel_d   = imm[SEL_W-1:0];
          else                          state_d = ST_ERROR;
        end
        OP_RDCNT: begin
          count_st_d = chan_count[sel_q];
        end
        OP_CLR: begin
          do_clr = 1'b1;
        end
        default: begin
          state_d = ST_ERROR;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_READY;
      sel_q      <= '0;
      left_st_q  <= 1'b0;
      right_st_q <= 1'b0;
      count_st_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      left_st_q  <= left_st_d;
      right_st_q <= right_st_d;
      count_st_q <= count_st_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel instances
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic hit;
    assign hit = (sel_q == SEL_W'(c));

    rotary_bank_channel #(
      .CNT_WIDTH       (CNT_WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i      (clock),
      .rst_i      (reset),
      .rot_i      (rotary[2*c +: 2]),
      .clr_i      (do_clr && hit),
      .rd_left_i  (do_rdl && hit),
      .rd_right_i (do_rdr && hit),
      .left_o     (chan_left[c]),
      .right_o    (chan_right[c]),
      .count_o    (chan_count[c])
    );
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rotary_left_status  = left_st_q;
  assign rotary_right_status = right_st_q;
  assign rotary_count        = count_st_q;
  assign rotary_error        = (state_q == ST_ERROR);

endmodule : rotary_bank

// File: tb/tb_rotary_bank.sv
// -----------------------------------------------------------------------------
// tb_rotary_bank
//
// Self-checking bench for rotary_bank (CHANNELS=2, CNT_WIDTH=8,
// DEBOUNCE_CYCLES=8). A table of {pin setting, instruction, expected outputs}
// records covers the basic read/select/clear flow. Hand-written sequences
// cover saturation, bounce filtering, a read on the same edge as an event,
// and Error entry and exit. Expectations that depend on
// ROTARY_BANK_DEBOUNCE_EN follow the same macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rotary_bank;
  import rotary_bank_pkg::*;

  localparam int CHANNELS  = 2;
  localparam int CNT_WIDTH = 8;
  localparam int DEB       = 8;
  localparam int HOLD      = 16;   // longer than either input-to-event latency

`ifdef ROTARY_BANK_DEBOUNCE_EN
  localparam int         LAT        = 3 + DEB;
  localparam logic [7:0] BOUNCE_CNT = 8'hFF;  // bounces filtered: one left event
`else
  localparam int         LAT        = 3;
  localparam logic [7:0] BOUNCE_CNT = 8'hFD;  // each 01->11 bounce counts
`endif

  logic                   clock = 1'b0;
  logic                   reset;
  logic [11:0]            inst;
  logic                   inst_en;
  logic [2*CHANNELS-1:0]  rotary;
  logic                   rotary_left_status;
  logic                   rotary_right_status;
  logic [CNT_WIDTH-1:0]   rotary_count;
  logic                   rotary_error;

  rotary_bank #(
    .CHANNELS        (CHANNELS),
    .CNT_WIDTH       (CNT_WIDTH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .inst                (inst),
    .inst_en             (inst_en),
    .rotary              (rotary),
    .rotary_left_status  (rotary_left_status),
    .rotary_right_status (rotary_right_status),
    .rotary_count        (rotary_count),
    .rotary_error        (rotary_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic l, input logic r,
                           input logic [7:0] c, input logic e);
    check({name, ".left"},  {15'd0, rotary_left_status},  {15'd0, l});
    check({name, ".right"}, {15'd0, rotary_right_status}, {15'd0, r});
    check({name, ".count"}, {8'd0, rotary_count},         {8'd0, c});
    check({name, ".error"}, {15'd0, rotary_error},        {15'd0, e});
  endtask

  // Each tick ends 1 ns after a rising edge, which is when inputs change and
  // outputs are sampled.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic exec(input logic [3:0] op, input logic [7:0] imm);
    inst    = {op, imm};
    inst_en = 1'b1;
    @(posedge clock);
    #1;
    inst_en = 1'b0;
    inst    = '0;
  endtask

  typedef struct {
    string      name;
    logic [3:0] rot;   // {ch1 B, ch1 A, ch0 B, ch0 A}
    logic [3:0] op;
    logic [7:0] imm;
    logic       l;
    logic       r;
    logic [7:0] c;
    logic       e;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [3:0] rot, input logic [3:0] op,
                              input logic [7:0] imm, input logic l, input logic r,
                              input logic [7:0] c, input logic e);
    vec_t v;
    v.name = n; v.rot = rot; v.op = op; v.imm = imm;
    v.l = l; v.r = r; v.c = c; v.e = e;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    vecs[0]  = mk("reset_state", 4'b0000, OP_NOP,   8'd0, 0, 0, 8'h00, 0);
    vecs[1]  = mk("ch0_01",      4'b0001, OP_NOP,   8'd0, 0, 0, 8'h00, 0);
    vecs[2]  = mk("ch0_11",      4'b0011, OP_NOP,   8'd0, 0, 0, 8'h00, 0);
    vecs[3]  = mk("rdls_set",    4'b0000, OP_RDLS,  8'd0, 1, 0, 8'h00, 0);
    vecs[4]  = mk("rdls_clear",  4'b0000, OP_RDLS,  8'd0, 0, 0, 8'h00, 0);
    vecs[5]  = mk("rdcnt_m1",    4'b0000, OP_RDCNT, 8'd0, 0, 0, 8'hFF, 0);
    vecs[6]  = mk("sel1",        4'b0000, OP_SEL,   8'd1, 0, 0, 8'hFF, 0);
    vecs[7]  = mk("ch1_10_a",    4'b1000, OP_NOP,   8'd0, 0, 0, 8'hFF, 0);
    vecs[8]  = mk("ch1_11_a",    4'b1100, OP_NOP,   8'd0, 0, 0, 8'hFF, 0);
    vecs[9]  = mk("ch1_10_b",    4'b1000, OP_NOP,   8'd0, 0, 0, 8'hFF, 0);
    vecs[10] = mk("ch1_11_b",    4'b1100, OP_NOP,   8'd0, 0, 0, 8'hFF, 0);
    vecs[11] = mk("ch1_10_c",    4'b1000, OP_NOP,   8'd0, 0, 0, 8'hFF, 0);
    vecs[12] = mk("ch1_11_c",    4'b1100, OP_NOP,   8'd0, 0, 0, 8'hFF, 0);
    vecs[13] = mk("rdrs_set",    4'b0000, OP_RDRS,  8'd0, 0, 1, 8'hFF, 0);
    vecs[14] = mk("rdrs_clear",  4'b0000, OP_RDRS,  8'd0, 0, 0, 8'hFF, 0);
    vecs[15] = mk("rdcnt_ch1",   4'b0000, OP_RDCNT, 8'd0, 0, 0, 8'h03, 0);
    vecs[16] = mk("sel0",        4'b0000, OP_SEL,   8'd0, 0, 0, 8'h03, 0);
    vecs[17] = mk("rdcnt_ch0",   4'b0000, OP_RDCNT, 8'd0, 0, 0, 8'hFF, 0);
    vecs[18] = mk("clr_ch0",     4'b0000, OP_CLR,   8'd0, 0, 0, 8'hFF, 0);
    vecs[19] = mk("rdcnt_clr",   4'b0000, OP_RDCNT, 8'd0, 0, 0, 8'h00, 0);

    reset   = 1'b1;
    inst    = '0;
    inst_en = 1'b0;
    rotary  = '0;
    tick(3);
    reset = 1'b0;

    // ---- Table-driven flow --------------------------------------------------
    for (int i = 0; i < 20; i++) begin
      rotary = vecs[i].rot;
      tick(HOLD);
      exec(vecs[i].op, vecs[i].imm);
      check_all(vecs[i].name, vecs[i].l, vecs[i].r, vecs[i].c, vecs[i].e);
    end

    // ---- 130 right turns on channel 1: saturates at +127 --------------------
    exec(OP_SEL, 8'd1);
    for (int t = 0; t < 130; t++) begin
      rotary[3:2] = 2'b10; tick(HOLD);
      rotary[3:2] = 2'b11; tick(HOLD);
    end
    exec(OP_RDCNT, 8'd0);
    check("sat_max", {8'd0, rotary_count}, 16'h007F);
    exec(OP_CLR, 8'd0);
    exec(OP_RDRS, 8'd0);
    check("clr_right", {15'd0, rotary_right_status}, 16'd0);
    exec(OP_RDCNT, 8'd0);
    check("clr_count", {8'd0, rotary_count}, 16'h0000);
    rotary[3:2] = 2'b00;

    // ---- Bounce on channel 0: 01, then 2-cycle 11/01 bounces, then 11 -------
    exec(OP_SEL, 8'd0);
    rotary[1:0] = 2'b01; tick(HOLD);
    for (int b = 0; b < 2; b++) begin
      rotary[1:0] = 2'b11; tick(2);
      rotary[1:0] = 2'b01; tick(2);
    end
    rotary[1:0] = 2'b11; tick(HOLD);
    exec(OP_RDLS, 8'd0);
    check("bounce_left", {15'd0, rotary_left_status}, 16'd1);
    exec(OP_RDCNT, 8'd0);
    check("bounce_count", {8'd0, rotary_count}, {8'd0, BOUNCE_CNT});

    // ---- RDLS on the same edge as a left event ------------------------------
    rotary[1:0] = 2'b01; tick(HOLD);
    rotary[1:0] = 2'b11;
    tick(LAT - 2);
    exec(OP_RDLS, 8'd0);                 // one edge before the event
    check("early_rdls", {15'd0, rotary_left_status}, 16'd0);
    exec(OP_RDLS, 8'd0);                 // on the event edge
    check("same_edge_rdls", {15'd0, rotary_left_status}, 16'd1);
    exec(OP_RDLS, 8'd0);
    check("consumed_rdls", {15'd0, rotary_left_status}, 16'd0);
    exec(OP_RDCNT, 8'd0);
    check("same_edge_count", {8'd0, rotary_count}, {8'd0, BOUNCE_CNT - 8'd1});

    // ---- Error: undefined opcode; instructions are then ignored -------------
    rotary[1:0] = 2'b10; tick(HOLD);
    rotary[1:0] = 2'b11; tick(HOLD);     // sets ch0 right flag
    exec(4'hF, 8'hAA);
    check_all("err_enter", 0, 0, BOUNCE_CNT - 8'd1, 1);
    exec(OP_RDRS, 8'd0);
    check_all("err_rdrs", 0, 0, BOUNCE_CNT - 8'd1, 1);
    exec(OP_RDCNT, 8'd0);
    check_all("err_rdcnt", 0, 0, BOUNCE_CNT - 8'd1, 1);

    // Asynchronous reset: outputs clear before the next clock edge.
    reset = 1'b1;
    #2;
    check_all("async_reset", 0, 0, 8'h00, 0);
    tick(1);
    reset = 1'b0;
    tick(1);
    exec(OP_RDCNT, 8'd0);
    check("reset_count", {8'd0, rotary_count}, 16'h0000);

    // ---- SEL boundaries and opcode 6 ----------------------------------------
    exec(OP_SEL, 8'd1);
    check("sel_last_ok", {15'd0, rotary_error}, 16'd0);
    exec(OP_SEL, 8'd2);
    check("sel_eq_channels", {15'd0, rotary_error}, 16'd1);
    reset = 1'b1; tick(1); reset = 1'b0;
    exec(4'h6, 8'h00);
    check("op6_error", {15'd0, rotary_error}, 16'd1);
    reset = 1'b1; tick(1); reset = 1'b0;
    check("err_cleared", {15'd0, rotary_error}, 16'd0);
    exec(OP_SEL, 8'd5);
    check("sel5_error", {15'd0, rotary_error}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rotary_bank

// File: doc/rotary_bank.md
# rotary_bank

Multi-channel successor to the single-encoder rotary peripheral. It monitors CHANNELS quadrature encoders, synchronises and debounces each one, and keeps a sticky left flag, a sticky right flag and a saturating signed position counter per channel. It sits on the processor's 12-bit instruction bus: opcode in inst[11:8], immediate in inst[7:0]. Reads, clears and channel selection are all driven by instructions.

## Interface
- CHANNELS, 2: number of encoders, 1..16.
- CNT_WIDTH, 8: position counter width, two's complement, 2..16.
- DEBOUNCE_CYCLES, 8: consecutive stable cycles required to accept a new input value, 1..255.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- inst  in  12  {opcode[3:0], imm[7:0]}.
- inst_en  in  1  when high, inst is executed on this edge.
- rotary  in  2*CHANNELS  {B,A} for channel c on rotary[2c+1:2c]; asynchronous.
- rotary_left_status  out  1  result of the last RDLS.
- rotary_right_status  out  1  result of the last RDRS.
- rotary_count  out  CNT_WIDTH  result of the last RDCNT.
- rotary_error  out  1  block is in Error state.

## Operation
- Opcodes:
  - NOP=0x0.
  - RDLS=0x1: read and clear the selected channel's left flag.
  - RDRS=0x2: read and clear the selected channel's right flag.
  - SEL=0x3: select channel imm.
  - RDCNT=0x4: latch the selected channel's count.
  - CLR=0x5: zero the selected channel's count and both flags.
- Top FSM has two states, Ready and Error. Reset enters Ready with selected channel 0.
- Ready to Error: an undefined opcode (0x6..0xF), or SEL with imm >= CHANNELS, while inst_en=1.
- Error is left only by reset. In Error, instructions are ignored and outputs hold their values. Channels keep tracking and counting.
- Per-channel input path: two-flop synchroniser, then debounce filter, then decoder.
- Decoder works on debounced {B,A}:
  - 01 followed by 11 gives a left event.
  - 10 followed by 11 gives a right event.
  - Any other transition gives no event.
  - At most one event per channel per cycle.
- Left event: sets left flag; count -1, saturating at -2^(CNT_WIDTH-1).
- Right event: sets right flag; count +1, saturating at 2^(CNT_WIDTH-1)-1.
- Flags are sticky, so multiple events before a read still read as 1.
- RDLS/RDRS output the flag OR a same-cycle event on the selected channel, then clear the flag. That event is consumed by the read.
- CLR on the same edge as an event: CLR wins; count=0 and flags=0.
- SEL takes effect for the next instruction. A SEL plus an event on the same edge loses nothing.
- inst_en=0: no state change, outputs hold.

## Timing
- Reset values: all outputs 0, all counts 0, all flags 0, debouncer state 00.
- Instruction executes at edge N; its output is registered and visible after edge N. Back-to-back instructions are allowed every cycle.
- Input to event latency: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1 cycle. An event is visible to an RDLS/RDRS executed on the following edge.
- A pulse shorter than DEBOUNCE_CYCLES restarts the stability counter and is discarded.
- Reset asserted mid-operation clears everything immediately, including a pending debounce.

## Configuration
- ROTARY_BANK_DEBOUNCE_EN defined: debounce filter present as described; DEBOUNCE_CYCLES applies.
- Not defined: synchroniser output drives the decoder directly. DEBOUNCE_CYCLES is ignored, latency becomes 3 cycles, and every bounce counts as a real transition.

## Structure
- Shared package holds the opcode constants, the Ready/Error state encoding and the opcode/immediate field positions.
- Sub-module rotary_bank_channel contains synchroniser, debouncer, decoder, flags and saturating counter. It is instantiated CHANNELS times with clear/read-strobe inputs.
- Top level holds the FSM, the select register (width max(1,clog2(CHANNELS))), instruction decode and the output registers.

## Test plan
- Channel 0: 01 for 30 ns, then 11, then 00 → RDLS returns 1; a second RDLS returns 0; RDCNT returns 0xFF (-1).
- SEL 1, then three 10→11 sequences on channel 1 → RDRS returns 1 once; RDCNT returns 0x03; channel 0 count unchanged.
- Debounce on: 01/00 bounces of 2 cycles, then clean 01→11 → exactly one left event, count -1. Debounce off: same stimulus shows multiple transitions reaching the decoder.
- 130 right turns with CNT_WIDTH=8 → RDCNT returns 0x7F; CLR then RDCNT returns 0x00.
- Opcode 0xF imm 0xAA → rotary_error=1; a subsequent RDRS leaves outputs unchanged; reset → error=0 and all outputs 0.
- SEL 5 with CHANNELS=2 → Error. Also: RDLS on the same edge as a left event → output 1, and the next RDLS returns 0.
